// File: rtl/multi_cycle_ctrl.sv
// Sequencer for a non-pipelined IF/ID/EXE/MEM/WB datapath with cancel, halt and retire counting.
// Optional watchdog is built only when MULTI_CYCLE_CTRL_TIMEOUT_EN is defined.
module multi_cycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IF_over,
    input  logic        ID_over,
    input  logic        EXE_over,
    input  logic        MEM_over,
    input  logic        WB_over,
    input  logic        EXE_skip_mem,
    input  logic        cancel,
    input  logic        halt,
    output logic        IF_valid,
    output logic        ID_valid,
    output logic        EXE_valid,
    output logic        MEM_valid,
    output logic        WB_valid,
    output logic        IF_ID_en,
    output logic        ID_EXE_en,
    output logic        EXE_MEM_en,
    output logic        MEM_WB_en,
    output logic        next_fetch,
    output logic [31:0] retire_cnt,
    output logic        timeout,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic        first_q;
    logic [31:0] retire_cnt_q;
    logic        active;
    logic        expire;
    logic        retire;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("multi_cycle_ctrl: TIMEOUT_CYCLES must be in 1..255");
    end

    assign active = ~reset;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:    if (IF_over)  state_d = S_ID;
            S_ID:    if (ID_over)  state_d = S_EXE;
            S_EXE:   if (EXE_over) state_d = EXE_skip_mem ? S_WB : S_MEM;
            S_MEM:   if (MEM_over) state_d = S_WB;
            S_WB:    if (WB_over)  state_d = halt ? S_HALT : S_IF;
            S_HALT:  if (!halt)    state_d = S_IF;
            default: state_d = S_IF;
        endcase
        // Cancel and watchdog expiry abandon the instruction; in IF this simply holds IF.
        if (state_q != S_HALT && (cancel || expire)) begin
            state_d = S_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IF;
            first_q      <= 1'b1;
            retire_cnt_q <= 32'd0;
        end else begin
            state_q <= state_d;
            first_q <= 1'b0;
            if (retire) begin
                retire_cnt_q <= retire_cnt_q + 32'd1;
            end
        end
    end

`ifdef MULTI_CYCLE_CTRL_TIMEOUT_EN
    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

    logic [7:0] wd_q, wd_d;
    logic       counting;

    // Dwell counter for the current stage; restarts whenever the state moves.
    assign counting = (state_q == S_ID) || (state_q == S_EXE) ||
                      (state_q == S_MEM) || (state_q == S_WB);
    assign expire   = counting && (wd_q == TimeoutLimit);
    assign wd_d     = (!counting || state_d != state_q) ? 8'd0 : wd_q + 8'd1;
    assign timeout  = active & expire & ~cancel;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= 8'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign IF_valid  = active && state_q == S_IF;
    assign ID_valid  = active && state_q == S_ID;
    assign EXE_valid = active && state_q == S_EXE;
    assign MEM_valid = active && state_q == S_MEM;
    assign WB_valid  = active && state_q == S_WB;

    assign IF_ID_en   = IF_valid  & IF_over  & ~cancel;
    assign ID_EXE_en  = ID_valid  & ID_over  & ~cancel;
    assign EXE_MEM_en = EXE_valid & EXE_over & ~cancel;
    assign MEM_WB_en  = MEM_valid & MEM_over & ~cancel;

    assign retire     = WB_valid & WB_over & ~cancel;
    assign next_fetch = active & (first_q | (state_d == S_IF && state_q != S_IF));
    assign retire_cnt = retire_cnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed vector table, force-based wrap test, watchdog tests
// (when MULTI_CYCLE_CTRL_TIMEOUT_EN is defined) and random stimulus against a stage-level model.
module tb_multi_cycle_ctrl;

`ifdef MULTI_CYCLE_CTRL_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    typedef struct packed {
        logic rst, ifo, ido, exo, skp, memo, wbo, cncl, hlt;
    } stim_t;

    typedef struct packed {
        logic [2:0]  st;
        logic [4:0]  val;
        logic [3:0]  en;
        logic        nf;
        logic        to;
        logic [31:0] cnt;
    } obs_t;

    typedef struct {
        stim_t       s;
        logic [2:0]  st;
        logic [4:0]  val;
        logic [3:0]  en;
        logic        nf;
        logic [31:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset, IF_over, ID_over, EXE_over, MEM_over, WB_over, EXE_skip_mem, cancel, halt;
    logic IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid;
    logic IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en, next_fetch, timeout;
    logic [31:0] retire_cnt;
    logic [2:0]  state;

    int compared = 0;
    int mismatched = 0;

    // Reference model: stage number, retire count, first-cycle flag, cycles spent in current stage
    int          mStage;
    logic [31:0] mCnt;
    bit          mFirst;
    int          mDwell;

    vec_t vecs[$];

    multi_cycle_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .IF_over(IF_over), .ID_over(ID_over), .EXE_over(EXE_over),
        .MEM_over(MEM_over), .WB_over(WB_over), .EXE_skip_mem(EXE_skip_mem),
        .cancel(cancel), .halt(halt),
        .IF_valid(IF_valid), .ID_valid(ID_valid), .EXE_valid(EXE_valid),
        .MEM_valid(MEM_valid), .WB_valid(WB_valid),
        .IF_ID_en(IF_ID_en), .ID_EXE_en(ID_EXE_en), .EXE_MEM_en(EXE_MEM_en),
        .MEM_WB_en(MEM_WB_en), .next_fetch(next_fetch), .retire_cnt(retire_cnt),
        .timeout(timeout), .state(state)
    );

    always #5 clk = ~clk;

    function automatic stim_t S(bit rst, bit ifo, bit ido, bit exo, bit skp,
                                bit memo, bit wbo, bit cncl, bit hlt);
        stim_t s;
        s = '{rst, ifo, ido, exo, skp, memo, wbo, cncl, hlt};
        return s;
    endfunction

    function automatic vec_t V(stim_t s, logic [2:0] st, logic [4:0] val, logic [3:0] en,
                               logic nf, logic [31:0] cnt);
        vec_t v;
        v.s = s; v.st = st; v.val = val; v.en = en; v.nf = nf; v.cnt = cnt;
        return v;
    endfunction

    function automatic obs_t sampleDut();
        obs_t o;
        o.st  = state;
        o.val = {WB_valid, MEM_valid, EXE_valid, ID_valid, IF_valid};
        o.en  = {MEM_WB_en, EXE_MEM_en, ID_EXE_en, IF_ID_en};
        o.nf  = next_fetch;
        o.to  = timeout;
        o.cnt = retire_cnt;
        return o;
    endfunction

    // Drive one cycle of inputs at the falling edge and settle before sampling
    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        reset = s.rst; IF_over = s.ifo; ID_over = s.ido; EXE_over = s.exo;
        EXE_skip_mem = s.skp; MEM_over = s.memo; WB_over = s.wbo;
        cancel = s.cncl; halt = s.hlt;
        #1;
    endtask

    task automatic checkOutput(input string name, input obs_t exp);
        obs_t act;
        act = sampleDut();
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got st=%0d val=%b en=%b nf=%b to=%b cnt=%h, want st=%0d val=%b en=%b nf=%b to=%b cnt=%h",
                     name, act.st, act.val, act.en, act.nf, act.to, act.cnt,
                     exp.st, exp.val, exp.en, exp.nf, exp.to, exp.cnt);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic obs_t modelExpect(input stim_t s, output int nxt);
        obs_t o;
        logic [4:0] over;
        int succ[5];
        bit expire;
        over = {s.wbo, s.memo, s.exo, s.ido, s.ifo};
        succ[0] = 1; succ[1] = 2; succ[2] = s.skp ? 4 : 3; succ[3] = 4; succ[4] = s.hlt ? 5 : 0;
        expire = 1'b0;
`ifdef MULTI_CYCLE_CTRL_TIMEOUT_EN
        expire = (mStage >= 1 && mStage <= 4 && mDwell == TO);
`endif
        if (mStage == 5)       nxt = s.hlt ? 5 : 0;
        else if (s.cncl)       nxt = 0;
        else if (expire)       nxt = 0;
        else if (over[mStage]) nxt = succ[mStage];
        else                   nxt = mStage;
        o = '0;
        o.st  = 3'(mStage);
        o.cnt = mCnt;
        if (!s.rst) begin
            if (mStage < 5) o.val[mStage] = 1'b1;
            for (int k = 0; k < 4; k++) o.en[k] = (mStage == k) && over[k] && !s.cncl;
            o.nf = mFirst || (nxt == 0 && mStage != 0);
            o.to = expire && !s.cncl;
        end
        return o;
    endfunction

    task automatic modelAdvance(input stim_t s, input int nxt);
        if (s.rst) begin
            mStage = 0; mCnt = 32'd0; mFirst = 1'b1; mDwell = 0;
        end else begin
            if (mStage == 4 && s.wbo && !s.cncl) mCnt = mCnt + 32'd1;
            mDwell = (nxt == mStage && mStage >= 1 && mStage <= 4) ? mDwell + 1 : 0;
            mStage = nxt;
            mFirst = 1'b0;
        end
    endtask

    task automatic step(input string name, input stim_t s, input bit chk);
        obs_t e;
        int nxt;
        applyStimulus(s);
        e = modelExpect(s, nxt);
        if (chk) checkOutput(name, e);
        modelAdvance(s, nxt);
    endtask

    initial begin
        stim_t idle;
        stim_t r;
        idle = S(0,0,0,0,0,0,0,0,0);
        reset = 1'b1; IF_over = 0; ID_over = 0; EXE_over = 0; MEM_over = 0;
        WB_over = 0; EXE_skip_mem = 0; cancel = 0; halt = 0;

        // Directed table: each row is checked before the rising edge it precedes
        vecs.push_back(V(S(1,0,0,0,0,0,0,0,0), 0, 5'h00, 4'h0, 0, 0));
        vecs.push_back(V(S(0,1,0,0,0,0,0,0,0), 0, 5'h01, 4'h1, 1, 0));
        vecs.push_back(V(S(0,0,1,0,0,0,0,0,0), 1, 5'h02, 4'h2, 0, 0));
        vecs.push_back(V(S(0,0,0,1,0,0,0,0,0), 2, 5'h04, 4'h4, 0, 0));
        vecs.push_back(V(S(0,0,0,0,0,1,0,0,0), 3, 5'h08, 4'h8, 0, 0));
        vecs.push_back(V(S(0,0,0,0,0,0,1,0,0), 4, 5'h10, 4'h0, 1, 0));
        vecs.push_back(V(idle,                 0, 5'h01, 4'h0, 0, 1));
        vecs.push_back(V(S(0,1,0,0,0,0,0,0,0), 0, 5'h01, 4'h1, 0, 1));
        vecs.push_back(V(S(0,0,1,0,0,0,0,0,0), 1, 5'h02, 4'h2, 0, 1));
        vecs.push_back(V(S(0,0,0,1,1,0,0,0,0), 2, 5'h04, 4'h4, 0, 1));
        vecs.push_back(V(idle,                 4, 5'h10, 4'h0, 0, 1));
        vecs.push_back(V(S(0,0,0,0,0,0,1,0,0), 4, 5'h10, 4'h0, 1, 1));
        vecs.push_back(V(S(0,1,0,0,0,0,0,0,0), 0, 5'h01, 4'h1, 0, 2));
        vecs.push_back(V(S(0,0,1,0,0,0,0,0,0), 1, 5'h02, 4'h2, 0, 2));
        vecs.push_back(V(S(0,0,0,1,0,0,0,0,0), 2, 5'h04, 4'h4, 0, 2));
        vecs.push_back(V(S(0,0,0,0,0,1,0,1,0), 3, 5'h08, 4'h0, 1, 2));
        vecs.push_back(V(idle,                 0, 5'h01, 4'h0, 0, 2));
        vecs.push_back(V(S(0,1,0,0,0,0,0,0,0), 0, 5'h01, 4'h1, 0, 2));
        vecs.push_back(V(S(0,0,1,0,0,0,0,0,0), 1, 5'h02, 4'h2, 0, 2));
        vecs.push_back(V(S(0,0,0,1,1,0,0,0,0), 2, 5'h04, 4'h4, 0, 2));
        vecs.push_back(V(S(0,0,0,0,0,0,1,1,0), 4, 5'h10, 4'h0, 1, 2));
        vecs.push_back(V(idle,                 0, 5'h01, 4'h0, 0, 2));
        vecs.push_back(V(S(0,1,0,0,0,0,0,1,0), 0, 5'h01, 4'h0, 0, 2));
        vecs.push_back(V(idle,                 0, 5'h01, 4'h0, 0, 2));
        vecs.push_back(V(S(0,0,1,0,0,0,1,0,0), 0, 5'h01, 4'h0, 0, 2));
        vecs.push_back(V(S(0,1,0,0,0,0,0,0,0), 0, 5'h01, 4'h1, 0, 2));
        vecs.push_back(V(S(0,1,0,1,0,1,1,0,0), 1, 5'h02, 4'h0, 0, 2));
        vecs.push_back(V(S(0,0,1,0,0,0,0,0,0), 1, 5'h02, 4'h2, 0, 2));
        vecs.push_back(V(S(0,0,0,1,0,0,0,0,0), 2, 5'h04, 4'h4, 0, 2));
        vecs.push_back(V(S(0,0,0,0,0,1,0,0,0), 3, 5'h08, 4'h8, 0, 2));
        vecs.push_back(V(S(0,0,0,0,0,0,1,0,1), 4, 5'h10, 4'h0, 0, 2));
        vecs.push_back(V(S(0,0,0,0,0,0,0,0,1), 5, 5'h00, 4'h0, 0, 3));
        vecs.push_back(V(S(0,0,0,0,0,0,0,0,1), 5, 5'h00, 4'h0, 0, 3));
        vecs.push_back(V(S(0,0,0,0,0,0,0,0,1), 5, 5'h00, 4'h0, 0, 3));
        vecs.push_back(V(idle,                 5, 5'h00, 4'h0, 1, 3));
        vecs.push_back(V(idle,                 0, 5'h01, 4'h0, 0, 3));
        vecs.push_back(V(S(0,1,0,0,0,0,0,0,0), 0, 5'h01, 4'h1, 0, 3));
        vecs.push_back(V(S(0,0,1,0,0,0,0,0,0), 1, 5'h02, 4'h2, 0, 3));
        vecs.push_back(V(S(0,0,0,1,1,0,0,0,0), 2, 5'h04, 4'h4, 0, 3));
        vecs.push_back(V(S(1,0,0,0,0,0,1,0,0), 4, 5'h00, 4'h0, 0, 3));
        vecs.push_back(V(idle,                 0, 5'h01, 4'h0, 1, 0));

        applyStimulus(S(1,0,0,0,0,0,0,0,0));
        for (int i = 0; i < vecs.size(); i++) begin
            obs_t e;
            applyStimulus(vecs[i].s);
            e = '{vecs[i].st, vecs[i].val, vecs[i].en, vecs[i].nf, 1'b0, vecs[i].cnt};
            checkOutput($sformatf("vec%0d", i), e);
        end

        // Retire counter wrap from an all-ones preload
        step("rst", S(1,0,0,0,0,0,0,0,0), 1'b0);
        step("post_rst", idle, 1'b1);
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        mCnt = 32'hFFFF_FFFF;
        step("preload", idle, 1'b1);
        release dut.retire_cnt_q;
        step("wrap_if", S(0,1,0,0,0,0,0,0,0), 1'b1);
        step("wrap_id", S(0,0,1,0,0,0,0,0,0), 1'b1);
        step("wrap_exe", S(0,0,0,1,1,0,0,0,0), 1'b1);
        step("wrap_wb", S(0,0,0,0,0,0,1,0,0), 1'b1);
        step("wrap_after", idle, 1'b1);
        checkValue("retire_wrap", retire_cnt, 32'd0);

`ifdef MULTI_CYCLE_CTRL_TIMEOUT_EN
        // Watchdog expiry in ID, then cancel racing an expiry
        step("wd_if", S(0,1,0,0,0,0,0,0,0), 1'b1);
        for (int i = 0; i < TO; i++) step("wd_hold", idle, 1'b1);
        step("wd_expire", idle, 1'b1);
        checkValue("wd_timeout", {31'd0, timeout}, 32'd1);
        checkValue("wd_fetch", {31'd0, next_fetch}, 32'd1);
        step("wd_back", idle, 1'b1);
        checkValue("wd_state", {29'd0, state}, 32'd0);
        step("wdc_if", S(0,1,0,0,0,0,0,0,0), 1'b1);
        for (int i = 0; i < TO; i++) step("wdc_hold", idle, 1'b1);
        step("wdc_cancel", S(0,0,0,0,0,0,0,1,0), 1'b1);
        checkValue("wdc_timeout", {31'd0, timeout}, 32'd0);
        checkValue("wdc_fetch", {31'd0, next_fetch}, 32'd1);
`endif

        // Random traffic against the stage-level model
        for (int i = 0; i < 3000; i++) begin
            r.rst  = ($urandom_range(0, 127) == 0);
            r.ifo  = 1'($urandom_range(0, 1));
            r.ido  = 1'($urandom_range(0, 1));
            r.exo  = 1'($urandom_range(0, 1));
            r.skp  = 1'($urandom_range(0, 1));
            r.memo = 1'($urandom_range(0, 1));
            r.wbo  = 1'($urandom_range(0, 1));
            r.cncl = ($urandom_range(0, 15) == 0);
            r.hlt  = ($urandom_range(0, 3) == 0);
            step("rand", r, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the watchdog limit in cycles, legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports IF_over, ID_over, EXE_over, MEM_over and WB_over, each input, 1 bit: the matching stage has completed.
REQ-005 The block SHALL have port EXE_skip_mem, input, 1 bit: qualified by EXE_over; 1 means the instruction needs no MEM stage.
REQ-006 The block SHALL have port cancel, input, 1 bit: abandon the current instruction and refetch.
REQ-007 The block SHALL have port halt, input, 1 bit: hold off the next fetch after retire.
REQ-008 The block SHALL have ports IF_valid, ID_valid, EXE_valid, MEM_valid and WB_valid, each output, 1 bit: the active-stage strobes.
REQ-009 The block SHALL have ports IF_ID_en, ID_EXE_en, EXE_MEM_en and MEM_WB_en, each output, 1 bit: inter-stage bus latch enables.
REQ-010 The block SHALL have port next_fetch, output, 1 bit: a one-cycle pulse that starts a fetch.
REQ-011 The block SHALL have port retire_cnt, output, 32 bits: the count of retired instructions.
REQ-012 The block SHALL have port timeout, output, 1 bit: a one-cycle pulse when the watchdog expires.
REQ-013 The block SHALL have port state, output, 3 bits: the current state, for display.

Function
REQ-014 States SHALL be encoded as IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL return to IF on the next cycle.
REQ-015 Exactly one X_valid SHALL be 1, matching the state; in HALT all X_valid SHALL be 0.
REQ-016 Stage transitions SHALL be: IF to ID on IF_over; ID to EXE on ID_over; EXE to WB on EXE_over with EXE_skip_mem=1, otherwise EXE to MEM on EXE_over; MEM to WB on MEM_over.
REQ-017 Without the corresponding _over, the block SHALL stay in the current state.
REQ-018 From WB on WB_over, the block SHALL go to IF if halt=0, otherwise to HALT; HALT SHALL go to IF in the cycle halt=0.
REQ-019 next_fetch SHALL be combinational and equal 1 in any cycle where the next state is IF and the current state is not IF.
REQ-020 next_fetch SHALL also be 1 in the first cycle after reset deasserts.
REQ-021 The latch enables SHALL be: IF_ID_en = IF_valid&IF_over; ID_EXE_en = ID_valid&ID_over; EXE_MEM_en = EXE_valid&EXE_over; MEM_WB_en = MEM_valid&MEM_over; EXE_MEM_en SHALL be 1 even when skipping MEM.
REQ-022 cancel=1 in any state other than HALT SHALL force the next state to IF and assert next_fetch, unless the current state is IF; cancel SHALL take priority over every _over.
REQ-023 A cancel that arrives while in IF SHALL leave the block in IF with no next_fetch pulse.
REQ-024 The latch enables SHALL be gated to 0 while cancel=1.
REQ-025 retire_cnt SHALL increment by 1, modulo 2^32, in each cycle where WB_valid&WB_over&~cancel; 0xFFFFFFFF SHALL wrap to 0.
REQ-026 cancel in WB with WB_over=1 SHALL NOT retire and SHALL NOT increment retire_cnt.
REQ-027 Any _over input for a stage other than the current one SHALL be ignored.

Reset
REQ-028 While reset=1 the block SHALL set state=IF, retire_cnt=0, the watchdog counter to 0 and timeout=0.
REQ-029 While reset=1, all valids, latch enables and next_fetch SHALL be 0.
REQ-030 reset asserted mid-instruction SHALL discard the instruction on the next edge without a retire count.

Configuration
REQ-031 With macro MULTI_CYCLE_CTRL_TIMEOUT_EN defined, an 8-bit watchdog SHALL clear on every state change and otherwise count cycles in states ID through WB; it SHALL NOT count in IF or HALT.
REQ-032 With MULTI_CYCLE_CTRL_TIMEOUT_EN defined, the watchdog reaching TIMEOUT_CYCLES SHALL pulse timeout for one cycle, force the next state to IF, assert next_fetch and clear the watchdog.
REQ-033 With MULTI_CYCLE_CTRL_TIMEOUT_EN defined, cancel in the same cycle as expiry SHALL win and timeout SHALL stay 0.
REQ-034 Without MULTI_CYCLE_CTRL_TIMEOUT_EN, no watchdog logic SHALL be built and timeout SHALL be tied to 0.

Verification
REQ-035 Reset for 2 cycles, then single-cycle _over in each stage with EXE_skip_mem=0 -> states 0,1,2,3,4,0; next_fetch in the first post-reset cycle and at WB to IF; retire_cnt=1.
REQ-036 EXE_over=1 with EXE_skip_mem=1 -> EXE goes to WB; MEM_valid never 1; EXE_MEM_en=1 for one cycle.
REQ-037 cancel=1 together with MEM_over=1 in MEM -> next state IF; MEM_WB_en=0; next_fetch=1; retire_cnt unchanged.
REQ-038 halt=1 at WB_over -> state 5 with all valids 0 for 3 cycles; halt=0 -> next_fetch=1, state 0.
REQ-039 Preload 0xFFFFFFFF retires through force then retire once -> retire_cnt=0.
REQ-040 With the macro defined and TIMEOUT_CYCLES=4, hold ID with ID_over=0 -> timeout pulses after 4 cycles in ID; state 0; next_fetch=1.
